// File: rtl/tachyon_pkg.sv
// Shared constants and types for the tachyon SoC peripherals.
// Register map, CTRL bit positions and DMA state encoding.
package tachyon_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_VSYNC     = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int CTRL_DST_FIXED = 3;
    localparam int CTRL_BUSY      = 4;
    localparam int CTRL_DONE      = 5;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ARMED = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise_o pulses for one clk cycle per synchronized 0->1 transition.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the asynchronous level through the synchronizer and edge stage
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-register flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/dma_controller.sv
// Memory-mapped word-copy DMA engine that masters the data bus
// while stalling the CPU; starts immediately or on vblank.
module dma_controller
    import tachyon_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cfg_sel,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_wenable,
    output logic [31:0] cfg_rdata,
    input  logic        vblank,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wenable,
    input  logic [31:0] bus_rdata,
    output logic        cpu_stall,
    output logic        irq
);

    dma_state_e state_q, state_d;

    logic [29:0] src_q, src_d;
    logic [29:0] dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic vsync_q, vsync_d;
    logic irq_en_q, irq_en_d;
    logic dst_fixed_q, dst_fixed_d;
    logic done_q, done_d;
    logic irq_q, irq_d;

    logic [29:0] cur_src_q, cur_src_d;
    logic [29:0] cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;

    logic vblank_rise;
    logic wr_src, wr_dst, wr_len, wr_ctrl;
    logic busy;

    sync_edge_detect u_vblank_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(vblank),
        .rise_o (vblank_rise)
    );

    assign wr_src  = cfg_wenable && (cfg_sel == REG_SRC);
    assign wr_dst  = cfg_wenable && (cfg_sel == REG_DST);
    assign wr_len  = cfg_wenable && (cfg_sel == REG_LEN);
    assign wr_ctrl = cfg_wenable && (cfg_sel == REG_CTRL);
    assign busy    = (state_q != DMA_IDLE);

    // Next-state, register updates and bus master outputs
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        vsync_d     = vsync_q;
        irq_en_d    = irq_en_q;
        dst_fixed_d = dst_fixed_q;
        done_d      = done_q;
        irq_d       = done_q & irq_en_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        bus_req     = 1'b0;
        bus_addr    = 32'h0;
        bus_wdata   = 32'h0;
        bus_wenable = 4'h0;

        unique case (state_q)
            DMA_IDLE: begin
                if (wr_src) src_d = cfg_wdata[31:2];
                if (wr_dst) dst_d = cfg_wdata[31:2];
                if (wr_len) len_d = cfg_wdata[LEN_W-1:0];
                if (wr_ctrl) begin
                    vsync_d     = cfg_wdata[CTRL_VSYNC];
                    irq_en_d    = cfg_wdata[CTRL_IRQ_EN];
                    dst_fixed_d = cfg_wdata[CTRL_DST_FIXED];
                    done_d      = 1'b0;
                    irq_d       = 1'b0;
                    if (cfg_wdata[CTRL_START]) begin
                        cur_src_d   = src_q;
                        cur_dst_d   = dst_q;
                        remaining_d = len_q;
                        if (len_q == '0)
                            done_d = 1'b1;
                        else if (cfg_wdata[CTRL_VSYNC])
                            state_d = DMA_ARMED;
                        else
                            state_d = DMA_READ;
                    end
                end
            end
            DMA_ARMED: begin
                if (wr_ctrl && !cfg_wdata[CTRL_START]) begin
                    state_d = DMA_IDLE;
                    done_d  = 1'b0;
                    irq_d   = 1'b0;
                end else if (vblank_rise) begin
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                bus_req  = 1'b1;
                bus_addr = {cur_src_q, 2'b00};
                state_d  = DMA_WRITE;
            end
            DMA_WRITE: begin
                bus_req     = 1'b1;
                bus_addr    = {cur_dst_q, 2'b00};
                bus_wdata   = bus_rdata;
                bus_wenable = 4'b1111;
                cur_src_d   = cur_src_q + 30'd1;
                if (!dst_fixed_q)
                    cur_dst_d = cur_dst_q + 30'd1;
                remaining_d = remaining_q - LEN_W'(1);
                if (remaining_q == LEN_W'(1)) begin
                    state_d = DMA_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DMA_READ;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    // Register readback for the selected configuration word
    always_comb begin
        cfg_rdata = 32'h0;
        unique case (cfg_sel)
            REG_SRC:  cfg_rdata = {src_q, 2'b00};
            REG_DST:  cfg_rdata = {dst_q, 2'b00};
            REG_LEN:  cfg_rdata = 32'(len_q);
            REG_CTRL: cfg_rdata = 32'({done_q, busy, dst_fixed_q,
                                       irq_en_q, vsync_q, 1'b0});
            default:  cfg_rdata = 32'h0;
        endcase
    end

    // State, configuration and working-copy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DMA_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            vsync_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            dst_fixed_q <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            vsync_q     <= vsync_d;
            irq_en_q    <= irq_en_d;
            dst_fixed_q <= dst_fixed_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
        end
    end

    assign cpu_stall = bus_req;
    assign irq       = irq_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller with a bus memory model
// and a scoreboard of expected bus reads and writes.
module tb_dma_controller;
    import tachyon_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_wdata = 32'h0;
    logic        cfg_wenable = 1'b0;
    logic [31:0] cfg_rdata;
    logic        vblank = 1'b0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wenable;
    logic [31:0] bus_rdata = 32'h0;
    logic        cpu_stall;
    logic        irq;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    logic [31:0] mem [logic [31:0]];

    int total = 0;
    int passed = 0;
    int stall_cnt = 0;

    dma_controller #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .cfg_wenable(cfg_wenable),
        .cfg_rdata  (cfg_rdata),
        .vblank     (vblank),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wenable(bus_wenable),
        .bus_rdata  (bus_rdata),
        .cpu_stall  (cpu_stall),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Bus slave: read data returned one cycle after the address
    always @(posedge clk) begin
        if (bus_req && bus_wenable == 4'h0)
            bus_rdata <= memrd(bus_addr);
        else
            bus_rdata <= 32'h0;
    end

    // Scoreboard: every bus cycle must match the next expected one
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_stall) stall_cnt++;
            if (bus_req) begin
                if (bus_wenable == 4'h0) begin
                    check("rd_pending", 32'(exp_rd.size() != 0), 32'd1);
                    if (exp_rd.size() != 0)
                        check("rd_addr", bus_addr, exp_rd.pop_front());
                end else begin
                    check("wr_wen", 32'(bus_wenable), 32'hF);
                    check("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
                    if (exp_wr.size() != 0) begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        check("wr_addr", bus_addr, w.addr);
                        check("wr_data", bus_wdata, w.data);
                    end
                end
            end
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        cfg_sel = sel;
        cfg_wdata = d;
        cfg_wenable = 1'b1;
        @(negedge clk);
        cfg_wenable = 1'b0;
    endtask

    task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst,
                               input int n, input bit fixed);
        for (int i = 0; i < n; i++) begin
            wr_t w;
            exp_rd.push_back(src + 32'(4 * i));
            w.addr = fixed ? dst : dst + 32'(4 * i);
            w.data = memrd(src + 32'(4 * i));
            exp_wr.push_back(w);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        cfg_sel = REG_CTRL;
        while (!cfg_rdata[CTRL_DONE] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(cfg_rdata[CTRL_DONE]), 32'd1);
    endtask

    initial begin
        mem[32'h100] = 32'hA1;
        mem[32'h104] = 32'hB2;
        mem[32'h108] = 32'hC3;
        for (int i = 0; i < 8; i++)
            mem[32'h200 + 32'(4 * i)] = 32'h1111_1111 * (i + 1);

        // Reset state
        #2;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_wen", 32'(bus_wenable), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        cfg_sel = REG_CTRL;
        #1 check("rst_ctrl", cfg_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Immediate 3-word copy
        cfg_write(REG_SRC, 32'h103);
        cfg_write(REG_DST, 32'h4000_0000);
        cfg_write(REG_LEN, 32'd3);
        cfg_sel = REG_SRC;
        #1 check("src_rdback", cfg_rdata, 32'h100);
        expect_copy(32'h100, 32'h4000_0000, 3, 1'b0);
        stall_cnt = 0;
        cfg_write(REG_CTRL, 32'h1);
        wait_done("t1_done");
        repeat (2) @(negedge clk);
        check("t1_stalls", 32'(stall_cnt), 32'd6);
        check("t1_ctrl", cfg_rdata, 32'h20);
        check("t1_irq", 32'(irq), 32'd0);
        check("t1_drained", 32'(exp_rd.size() + exp_wr.size()), 32'd0);

        // LEN=0 with interrupt enabled
        cfg_write(REG_LEN, 32'd0);
        stall_cnt = 0;
        cfg_write(REG_CTRL, 32'h5);
        cfg_sel = REG_CTRL;
        #1 check("t2_done", 32'(cfg_rdata[CTRL_DONE]), 32'd1);
        check("t2_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("t2_irq", 32'(irq), 32'd1);
        repeat (4) @(negedge clk);
        check("t2_stalls", 32'(stall_cnt), 32'd0);

        // Vsync-triggered single word
        cfg_write(REG_DST, 32'h4000_1000);
        cfg_write(REG_LEN, 32'd1);
        expect_copy(32'h100, 32'h4000_1000, 1, 1'b0);
        stall_cnt = 0;
        cfg_write(REG_CTRL, 32'h3);
        check("t3_irq_clr", 32'(irq), 32'd0);
        repeat (20) @(negedge clk);
        check("t3_armed_idle", 32'(stall_cnt), 32'd0);
        cfg_sel = REG_CTRL;
        #1 check("t3_busy", 32'(cfg_rdata[CTRL_BUSY]), 32'd1);
        vblank = 1'b1;
        @(negedge clk);
        check("t3_edge1", 32'(bus_req), 32'd0);
        @(negedge clk);
        check("t3_edge2", 32'(bus_req), 32'd0);
        @(negedge clk);
        check("t3_edge3", 32'(bus_req), 32'd1);
        wait_done("t3_done");
        check("t3_stalls", 32'(stall_cnt), 32'd2);
        vblank = 1'b0;
        repeat (5) @(negedge clk);

        // Abort while armed
        stall_cnt = 0;
        cfg_write(REG_CTRL, 32'h3);
        cfg_write(REG_CTRL, 32'h0);
        cfg_sel = REG_CTRL;
        #1 check("t4_idle", 32'(cfg_rdata[CTRL_BUSY]), 32'd0);
        vblank = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_stalls", 32'(stall_cnt), 32'd0);
        check("t4_done", 32'(cfg_rdata[CTRL_DONE]), 32'd0);
        vblank = 1'b0;
        repeat (5) @(negedge clk);

        // Fixed destination
        cfg_write(REG_SRC, 32'h200);
        cfg_write(REG_DST, 32'hE000_0008);
        cfg_write(REG_LEN, 32'd4);
        expect_copy(32'h200, 32'hE000_0008, 4, 1'b1);
        stall_cnt = 0;
        cfg_write(REG_CTRL, 32'h9);
        wait_done("t5_done");
        check("t5_stalls", 32'(stall_cnt), 32'd8);
        check("t5_drained", 32'(exp_rd.size() + exp_wr.size()), 32'd0);
        cfg_sel = REG_SRC;
        #1 check("t5_src_kept", cfg_rdata, 32'h200);

        // Reset during the second WRITE of a 5-word copy
        cfg_write(REG_SRC, 32'h200);
        cfg_write(REG_DST, 32'h5000_0000);
        cfg_write(REG_LEN, 32'd5);
        expect_copy(32'h200, 32'h5000_0000, 2, 1'b0);
        cfg_write(REG_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        check("t6_in_write", 32'(bus_wenable), 32'hF);
        #1 rst = 1'b1;
        #1 check("t6_req_drop", 32'(bus_req), 32'd0);
        check("t6_stall_drop", 32'(cpu_stall), 32'd0);
        for (int s = 0; s < 4; s++) begin
            cfg_sel = 2'(s);
            #1 check("t6_reg_zero", cfg_rdata, 32'd0);
        end
        check("t6_drained", 32'(exp_rd.size() + exp_wr.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh start after reset
        cfg_write(REG_SRC, 32'h104);
        cfg_write(REG_DST, 32'h6000_0000);
        cfg_write(REG_LEN, 32'd2);
        expect_copy(32'h104, 32'h6000_0000, 2, 1'b0);
        stall_cnt = 0;
        cfg_write(REG_CTRL, 32'h1);
        wait_done("t7_done");
        check("t7_stalls", 32'(stall_cnt), 32'd4);
        check("t7_drained", 32'(exp_rd.size() + exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
